// File: rtl/iot_riscv_hazard_pkg.sv
// Shared types and helpers for the iot_riscv hazard controller.
// Optional feature macro: IOT_RISCV_HAZARD_PERF_EN.
package iot_riscv_hazard_pkg;

   localparam int FCNT_W    = 2;
   localparam int IDX_MAX_W = 8;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FLUSH,
      ST_DRAIN
   } hz_state_e;

   typedef enum logic [2:0] {
      M_RST,
      M_STALL,
      M_FLUSH,
      M_DRAIN,
      M_DATA,
      M_IDLE,
      M_RUN
   } hz_mode_e;

   // x0 is hardwired, so it never matches anything.
   function automatic logic idx_hit(
      input logic [IDX_MAX_W-1:0] a,
      input logic [IDX_MAX_W-1:0] b
   );
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/iot_riscv_hazard_fwd_sel.sv
// Priority forwarding match and mux for one source operand.
// Stage 0 is the youngest producer and wins over older ones.
module iot_riscv_hazard_fwd_sel
   import iot_riscv_hazard_pkg::*;
#(
   parameter int DW     = 32,
   parameter int REG_AW = 5,
   parameter int NFWD   = 2
) (
   input  logic                   uses,
   input  logic [REG_AW-1:0]      idx,
   input  logic [NFWD-1:0]        fwd_valid,
   input  logic [NFWD-1:0]        fwd_rdy,
   input  logic [NFWD*REG_AW-1:0] fwd_rd_index,
   input  logic [NFWD*DW-1:0]     fwd_data,
   output logic                   en,
   output logic [DW-1:0]          data,
   output logic                   hit_not_ready
);

   logic [NFWD-1:0] hit;

   always_comb begin
      for (int k = 0; k < NFWD; k++) begin
         hit[k] = uses && fwd_valid[k] && idx_hit(
            IDX_MAX_W'(idx),
            IDX_MAX_W'(fwd_rd_index[k*REG_AW +: REG_AW]));
      end
   end

   always_comb begin
      en            = 1'b0;
      data          = '0;
      hit_not_ready = 1'b0;
      // Walk oldest to youngest so the nearest hit is applied last.
      for (int k = NFWD - 1; k >= 0; k--) begin
         if (hit[k]) begin
            en            = fwd_rdy[k];
            hit_not_ready = !fwd_rdy[k];
            data          = fwd_rdy[k] ? fwd_data[k*DW +: DW] : '0;
         end
      end
   end

endmodule

// File: rtl/iot_riscv_hazard_ctrl.sv
// Hazard controller: scoreboard, forwarding, branch flush, fence drain.
// Optional perf counters behind IOT_RISCV_HAZARD_PERF_EN.
module iot_riscv_hazard_ctrl
   import iot_riscv_hazard_pkg::*;
#(
   parameter int DW        = 32,
   parameter int REG_AW    = 5,
   parameter int NFWD      = 2,
   parameter int FLUSH_CYC = 1
) (
   input  logic                   main_clk_i,
   input  logic                   main_rst_i,
   input  logic                   id_valid_i,
   input  logic [REG_AW-1:0]      id_ra_index_i,
   input  logic [REG_AW-1:0]      id_rb_index_i,
   input  logic                   id_uses_ra_i,
   input  logic                   id_uses_rb_i,
   input  logic [REG_AW-1:0]      id_rd_index_i,
   input  logic                   id_long_i,
   input  logic                   id_fence_i,
   input  logic [NFWD-1:0]        fwd_valid_i,
   input  logic [NFWD-1:0]        fwd_rdy_i,
   input  logic [NFWD*REG_AW-1:0] fwd_rd_index_i,
   input  logic [NFWD*DW-1:0]     fwd_data_i,
   input  logic                   wb_valid_i,
   input  logic [REG_AW-1:0]      wb_rd_index_i,
   input  logic                   branch_taken_i,
   input  logic                   pipe_stall_i,
   output logic                   if_ready_o,
   output logic                   id_ready_o,
   output logic                   ex_ready_o,
   output logic                   id_clear_o,
   output logic                   ex_clear_o,
   output logic                   hazard_o,
   output logic                   fwd_a_en_o,
   output logic                   fwd_b_en_o,
   output logic [DW-1:0]          fwd_a_data_o,
   output logic [DW-1:0]          fwd_b_data_o,
   output logic                   sb_busy_o
`ifdef IOT_RISCV_HAZARD_PERF_EN
   ,
   output logic [31:0]            perf_stall_cnt_o,
   output logic [31:0]            perf_flush_cnt_o
`endif
);

   localparam int NREG = 1 << REG_AW;

   hz_state_e         state_q;
   hz_mode_e          mode;
   logic [FCNT_W-1:0] cnt_q;
   logic              br_pend_q;
   logic [NREG-1:0]   sb_q;
   logic [NREG-1:0]   sb_set;
   logic [NREG-1:0]   sb_clr;
   logic [NREG-1:0]   sb_n;
   logic              sb_busy_q;

   logic          a_en, b_en;
   logic          a_nr, b_nr;
   logic [DW-1:0] a_data, b_data;

   logic br_eff;
   logic drain_done;
   logic fence_wait;
   logic raw_a, raw_b, waw;
   logic data_stall;
   logic issue;

   iot_riscv_hazard_fwd_sel #(
      .DW     (DW),
      .REG_AW (REG_AW),
      .NFWD   (NFWD)
   ) u_fwd_a (
      .uses          (id_uses_ra_i),
      .idx           (id_ra_index_i),
      .fwd_valid     (fwd_valid_i),
      .fwd_rdy       (fwd_rdy_i),
      .fwd_rd_index  (fwd_rd_index_i),
      .fwd_data      (fwd_data_i),
      .en            (a_en),
      .data          (a_data),
      .hit_not_ready (a_nr)
   );

   iot_riscv_hazard_fwd_sel #(
      .DW     (DW),
      .REG_AW (REG_AW),
      .NFWD   (NFWD)
   ) u_fwd_b (
      .uses          (id_uses_rb_i),
      .idx           (id_rb_index_i),
      .fwd_valid     (fwd_valid_i),
      .fwd_rdy       (fwd_rdy_i),
      .fwd_rd_index  (fwd_rd_index_i),
      .fwd_data      (fwd_data_i),
      .en            (b_en),
      .data          (b_data),
      .hit_not_ready (b_nr)
   );

   assign br_eff     = branch_taken_i | br_pend_q;
   assign drain_done = (sb_q == '0) && (fwd_valid_i == '0);

   assign fence_wait = (state_q == ST_DRAIN) ? !drain_done
                     : (id_valid_i && id_fence_i && !drain_done);

   assign raw_a = id_uses_ra_i && (id_ra_index_i != '0)
               && sb_q[id_ra_index_i] && !a_en;
   assign raw_b = id_uses_rb_i && (id_rb_index_i != '0)
               && sb_q[id_rb_index_i] && !b_en;
   assign waw   = !id_long_i && (id_rd_index_i != '0)
               && sb_q[id_rd_index_i];

   assign data_stall = id_valid_i
                    && (raw_a || raw_b || a_nr || b_nr || waw);

   always_comb begin
      if (main_rst_i)
         mode = M_RST;
      else if (pipe_stall_i)
         mode = M_STALL;
      else if (br_eff || (state_q == ST_FLUSH))
         mode = M_FLUSH;
      else if (fence_wait)
         mode = M_DRAIN;
      else if (data_stall)
         mode = M_DATA;
      else if (!id_valid_i)
         mode = M_IDLE;
      else
         mode = M_RUN;
   end

   always_comb begin
      if_ready_o = 1'b0;
      id_ready_o = 1'b0;
      ex_ready_o = 1'b0;
      id_clear_o = 1'b0;
      ex_clear_o = 1'b0;
      unique case (mode)
         M_RST: begin
            id_clear_o = 1'b1;
            ex_clear_o = 1'b1;
         end
         M_STALL: begin
         end
         // Wrong-path ID instr is dropped; EX takes a bubble.
         M_FLUSH: begin
            if_ready_o = 1'b1;
            ex_ready_o = 1'b1;
            id_clear_o = 1'b1;
            ex_clear_o = 1'b1;
         end
         M_DRAIN, M_DATA: begin
            ex_ready_o = 1'b1;
            ex_clear_o = 1'b1;
         end
         M_IDLE: begin
            if_ready_o = 1'b1;
            id_ready_o = 1'b1;
            ex_ready_o = 1'b1;
            id_clear_o = 1'b1;
         end
         default: begin
            if_ready_o = 1'b1;
            id_ready_o = 1'b1;
            ex_ready_o = 1'b1;
         end
      endcase
   end

   assign hazard_o     = !if_ready_o;
   assign fwd_a_en_o   = !main_rst_i && a_en;
   assign fwd_b_en_o   = !main_rst_i && b_en;
   assign fwd_a_data_o = main_rst_i ? '0 : a_data;
   assign fwd_b_data_o = main_rst_i ? '0 : b_data;
   assign sb_busy_o    = sb_busy_q;

   assign issue = id_valid_i && id_ready_o && id_long_i
               && (id_rd_index_i != '0);

   assign sb_set = issue ? (NREG'(1) << id_rd_index_i) : '0;
   assign sb_clr = wb_valid_i ? (NREG'(1) << wb_rd_index_i) : '0;
   assign sb_n   = (sb_q & ~sb_clr) | sb_set;

   always_ff @(posedge main_clk_i) begin
      if (main_rst_i) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         br_pend_q <= 1'b0;
         sb_q      <= '0;
         sb_busy_q <= 1'b0;
      end else begin
         sb_q      <= sb_n;
         sb_busy_q <= |sb_n;
         if (pipe_stall_i) begin
            if (branch_taken_i)
               br_pend_q <= 1'b1;
         end else begin
            br_pend_q <= 1'b0;
            if (br_eff) begin
               if (FLUSH_CYC > 1) begin
                  state_q <= ST_FLUSH;
                  cnt_q   <= FCNT_W'(FLUSH_CYC - 1);
               end else begin
                  state_q <= ST_RUN;
                  cnt_q   <= '0;
               end
            end else begin
               unique case (state_q)
                  ST_FLUSH: begin
                     cnt_q <= cnt_q - 1'b1;
                     if (cnt_q == FCNT_W'(1))
                        state_q <= ST_RUN;
                  end
                  ST_DRAIN: begin
                     if (drain_done)
                        state_q <= ST_RUN;
                  end
                  default: begin
                     if (fence_wait)
                        state_q <= ST_DRAIN;
                  end
               endcase
            end
         end
      end
   end

`ifdef IOT_RISCV_HAZARD_PERF_EN
   always_ff @(posedge main_clk_i) begin
      if (main_rst_i) begin
         perf_stall_cnt_o <= '0;
         perf_flush_cnt_o <= '0;
      end else begin
         if ((mode == M_DATA) && (perf_stall_cnt_o != '1))
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
         if ((mode == M_FLUSH) && (perf_flush_cnt_o != '1))
            perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_iot_riscv_hazard_ctrl.sv
// Bench for iot_riscv_hazard_ctrl: vector table, corner sequences,
// and random traffic against a rule-level reference model.
module tb_iot_riscv_hazard_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NF = 2;
   localparam int FC = 3;
   localparam logic [31:0] D0 = 32'hAAAA_0000;
   localparam logic [31:0] D1 = 32'h5555_1111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, id_valid, ua, ub, id_long, id_fence;
   logic [AW-1:0]    ra, rb, rd, wb_rd;
   logic [NF-1:0]    fwd_valid, fwd_rdy;
   logic [NF*AW-1:0] fwd_rd;
   logic [NF*DW-1:0] fwd_data;
   logic             wb_valid, branch, stall;
   logic             if_rdy, id_rdy, ex_rdy, id_clr, ex_clr, hazard;
   logic             a_en, b_en, sb_busy;
   logic [DW-1:0]    a_data, b_data;
`ifdef IOT_RISCV_HAZARD_PERF_EN
   logic [31:0]      p_stall, p_flush;
`endif

   iot_riscv_hazard_ctrl #(
      .DW(DW), .REG_AW(AW), .NFWD(NF), .FLUSH_CYC(FC)
   ) dut (
      .main_clk_i(clk), .main_rst_i(rst),
      .id_valid_i(id_valid),
      .id_ra_index_i(ra), .id_rb_index_i(rb),
      .id_uses_ra_i(ua), .id_uses_rb_i(ub),
      .id_rd_index_i(rd), .id_long_i(id_long), .id_fence_i(id_fence),
      .fwd_valid_i(fwd_valid), .fwd_rdy_i(fwd_rdy),
      .fwd_rd_index_i(fwd_rd), .fwd_data_i(fwd_data),
      .wb_valid_i(wb_valid), .wb_rd_index_i(wb_rd),
      .branch_taken_i(branch), .pipe_stall_i(stall),
      .if_ready_o(if_rdy), .id_ready_o(id_rdy), .ex_ready_o(ex_rdy),
      .id_clear_o(id_clr), .ex_clear_o(ex_clr), .hazard_o(hazard),
      .fwd_a_en_o(a_en), .fwd_b_en_o(b_en),
      .fwd_a_data_o(a_data), .fwd_b_data_o(b_data),
      .sb_busy_o(sb_busy)
`ifdef IOT_RISCV_HAZARD_PERF_EN
      ,
      .perf_stall_cnt_o(p_stall), .perf_flush_cnt_o(p_flush)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkd(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic clr_in();
      rst = 0; id_valid = 0; ua = 0; ub = 0; id_long = 0; id_fence = 0;
      ra = 0; rb = 0; rd = 0; wb_rd = 0; wb_valid = 0;
      fwd_valid = 0; fwd_rdy = 0; fwd_rd = 0; fwd_data = {D1, D0};
      branch = 0; stall = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr_in();
      rst = 1;
      tick();
      rst = 0;
   endtask

   // ---------------- reference model ----------------
   logic [31:0] pend;
   int          flush_left;
   logic        br_late, draining, busy_r;
   int          m_stall_n, m_flush_n;
   logic        e_if, e_id, e_ex, e_idc, e_exc, e_aen, e_ben;
   logic [31:0] e_ad, e_bd;
   logic        e_br, e_done, e_fwait, e_issue, e_dmode, e_fmode;

   task automatic model_reset();
      pend = 0; flush_left = 0; br_late = 0; draining = 0; busy_r = 0;
      m_stall_n = 0; m_flush_n = 0;
   endtask

   task automatic operand(input logic u, input logic [AW-1:0] idx,
                          output logic en, output logic [31:0] d,
                          output logic blk);
      bit found;
      en = 0; d = 0; blk = 0; found = 0;
      if (u && idx != 0) begin
         for (int k = 0; k < NF; k++) begin
            if (!found && fwd_valid[k] && fwd_rd[k*AW +: AW] == idx) begin
               found = 1;
               en = fwd_rdy[k];
               blk = !fwd_rdy[k];
               if (en) d = fwd_data[k*DW +: DW];
            end
         end
      end
   endtask

   task automatic model_eval();
      logic ablk, bblk, raw, waw;
      operand(ua, ra, e_aen, e_ad, ablk);
      operand(ub, rb, e_ben, e_bd, bblk);
      e_done = (pend == 0) && (fwd_valid == 0);
      e_br = branch || br_late;
      e_fwait = draining ? !e_done : (id_valid && id_fence && !e_done);
      raw = ablk || bblk || (ua && ra != 0 && pend[ra] && !e_aen)
         || (ub && rb != 0 && pend[rb] && !e_ben);
      waw = !id_long && rd != 0 && pend[rd];
      e_dmode = 0; e_fmode = 0;
      {e_if, e_id, e_ex, e_idc, e_exc} = 5'b11100;
      if (rst) begin
         {e_if, e_id, e_ex, e_idc, e_exc} = 5'b00011;
         e_aen = 0; e_ben = 0; e_ad = 0; e_bd = 0;
      end else if (stall) begin
         {e_if, e_id, e_ex, e_idc, e_exc} = 5'b00000;
      end else if (e_br || flush_left > 0) begin
         {e_if, e_id, e_ex, e_idc, e_exc} = 5'b10111;
         e_fmode = 1;
      end else if (e_fwait) begin
         {e_if, e_id, e_ex, e_idc, e_exc} = 5'b00101;
      end else if (id_valid && (raw || waw)) begin
         {e_if, e_id, e_ex, e_idc, e_exc} = 5'b00101;
         e_dmode = 1;
      end else if (!id_valid) begin
         {e_if, e_id, e_ex, e_idc, e_exc} = 5'b11110;
      end
      e_issue = id_valid && e_id && id_long && rd != 0;
   endtask

   task automatic model_step();
      if (rst) begin
         model_reset();
      end else begin
         if (wb_valid) pend[wb_rd] = 0;
         if (e_issue) pend[rd] = 1;
         if (e_dmode) m_stall_n++;
         if (e_fmode) m_flush_n++;
         if (stall) begin
            if (branch) br_late = 1;
         end else begin
            br_late = 0;
            if (e_br) begin
               flush_left = FC - 1;
               draining = 0;
            end else if (flush_left > 0) begin
               flush_left--;
            end else if (draining) begin
               if (e_done) draining = 0;
            end else if (e_fwait) begin
               draining = 1;
            end
         end
         busy_r = (pend != 0);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic          vld, u_a, u_b, stl;
      logic [AW-1:0] a, b, r0, r1;
      logic [1:0]    fv, fr;
      logic [4:0]    exp;   // if,id,ex,id_clear,ex_clear
      logic [1:0]    asel, bsel;
   } vec_t;

   vec_t tv [10];
   logic [31:0] want_d;

   initial begin
      tv[0] = '{1,1,0,0, 5'd5,5'd0,5'd5,5'd5, 2'b11,2'b01, 5'b11100, 2'd1,2'd0};
      tv[1] = '{1,1,0,0, 5'd5,5'd0,5'd5,5'd5, 2'b11,2'b10, 5'b00101, 2'd0,2'd0};
      tv[2] = '{1,1,0,0, 5'd5,5'd0,5'd0,5'd5, 2'b10,2'b10, 5'b11100, 2'd2,2'd0};
      tv[3] = '{1,1,0,0, 5'd0,5'd0,5'd0,5'd0, 2'b11,2'b11, 5'b11100, 2'd0,2'd0};
      tv[4] = '{1,0,0,0, 5'd5,5'd0,5'd5,5'd0, 2'b01,2'b00, 5'b11100, 2'd0,2'd0};
      tv[5] = '{1,1,1,0, 5'd6,5'd6,5'd7,5'd6, 2'b10,2'b10, 5'b11100, 2'd2,2'd2};
      tv[6] = '{0,0,0,0, 5'd0,5'd0,5'd0,5'd0, 2'b00,2'b00, 5'b11110, 2'd0,2'd0};
      tv[7] = '{1,1,0,1, 5'd5,5'd0,5'd5,5'd0, 2'b01,2'b01, 5'b00000, 2'd1,2'd0};
      tv[8] = '{0,1,0,0, 5'd5,5'd0,5'd5,5'd0, 2'b01,2'b00, 5'b11110, 2'd0,2'd0};
      tv[9] = '{1,1,1,0, 5'd3,5'd4,5'd3,5'd4, 2'b11,2'b01, 5'b00101, 2'd1,2'd0};

      clr_in();
      tick();

      // reset state
      rst = 1; id_valid = 1; ua = 1; ra = 5;
      fwd_valid = 2'b01; fwd_rdy = 2'b01; fwd_rd = {5'd0, 5'd5};
      @(negedge clk);
      chk1("rst_if_ready", if_rdy, 0);
      chk1("rst_id_ready", id_rdy, 0);
      chk1("rst_ex_ready", ex_rdy, 0);
      chk1("rst_id_clear", id_clr, 1);
      chk1("rst_ex_clear", ex_clr, 1);
      chk1("rst_fwd_a_en", a_en, 0);
      chkd("rst_fwd_a_data", a_data, 0);
      tick();
      @(negedge clk);
      chk1("rst_sb_busy", sb_busy, 0);
      tick();
      clr_in();

      // combinational vectors from an empty scoreboard
      for (int i = 0; i < 10; i++) begin
         clr_in();
         id_valid = tv[i].vld; ua = tv[i].u_a; ub = tv[i].u_b;
         stall = tv[i].stl; ra = tv[i].a; rb = tv[i].b;
         fwd_rd = {tv[i].r1, tv[i].r0};
         fwd_valid = tv[i].fv; fwd_rdy = tv[i].fr;
         @(negedge clk);
         chk1($sformatf("vec%0d_if_ready", i), if_rdy, tv[i].exp[4]);
         chk1($sformatf("vec%0d_id_ready", i), id_rdy, tv[i].exp[3]);
         chk1($sformatf("vec%0d_ex_ready", i), ex_rdy, tv[i].exp[2]);
         chk1($sformatf("vec%0d_id_clear", i), id_clr, tv[i].exp[1]);
         chk1($sformatf("vec%0d_ex_clear", i), ex_clr, tv[i].exp[0]);
         chk1($sformatf("vec%0d_hazard", i), hazard, !tv[i].exp[4]);
         chk1($sformatf("vec%0d_a_en", i), a_en, tv[i].asel != 0);
         chk1($sformatf("vec%0d_b_en", i), b_en, tv[i].bsel != 0);
         want_d = (tv[i].asel == 1) ? D0 : (tv[i].asel == 2) ? D1 : 32'd0;
         chkd($sformatf("vec%0d_a_data", i), a_data, want_d);
         want_d = (tv[i].bsel == 1) ? D0 : (tv[i].bsel == 2) ? D1 : 32'd0;
         chkd($sformatf("vec%0d_b_data", i), b_data, want_d);
         tick();
      end

      // long load x7, dependent read stalls until after wb
      do_reset();
      id_valid = 1; id_long = 1; rd = 7;
      @(negedge clk);
      chk1("ld_issue_id_ready", id_rdy, 1);
      tick();
      id_long = 0; rd = 8; ua = 1; ra = 7;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("ld_raw_hazard", hazard, 1);
         chk1("ld_sb_busy", sb_busy, 1);
         tick();
      end
      wb_valid = 1; wb_rd = 7;
      @(negedge clk);
      chk1("ld_wb_cycle_hazard", hazard, 1);
      tick();
      wb_valid = 0;
      @(negedge clk);
      chk1("ld_after_wb_hazard", hazard, 0);
      chk1("ld_after_wb_id_ready", id_rdy, 1);
      chk1("ld_after_wb_sb_busy", sb_busy, 0);
      tick();

      // same-cycle set and clear of x3: set wins
      do_reset();
      id_valid = 1; id_long = 1; rd = 3;
      tick();
      wb_valid = 1; wb_rd = 3;
      @(negedge clk);
      chk1("setclr_id_ready", id_rdy, 1);
      tick();
      clr_in();
      @(negedge clk);
      chk1("setclr_sb_busy", sb_busy, 1);
      tick();
      wb_valid = 1; wb_rd = 3;
      tick();
      wb_valid = 0;
      @(negedge clk);
      chk1("setclr_clear_sb_busy", sb_busy, 0);
      tick();

      // branch flush lasts FC cycles
      do_reset();
      id_valid = 1; branch = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk1($sformatf("flush%0d_id_clear", i), id_clr, i < FC);
         chk1($sformatf("flush%0d_id_ready", i), id_rdy, i >= FC);
         tick();
         branch = 0;
      end
      // branch under backend stall is deferred
      stall = 1; branch = 1;
      @(negedge clk);
      chk1("brstall_id_clear", id_clr, 0);
      chk1("brstall_if_ready", if_rdy, 0);
      tick();
      branch = 0;
      @(negedge clk);
      chk1("brstall2_id_clear", id_clr, 0);
      tick();
      stall = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk1($sformatf("brlate%0d_id_clear", i), id_clr, i < FC);
         tick();
      end

      // fence drains two pending loads and in-flight producers
      do_reset();
      id_valid = 1; id_long = 1; rd = 9;
      tick();
      rd = 10;
      tick();
      id_long = 0; rd = 0; id_fence = 1;
      @(negedge clk);
      chk1("fence_wait0", id_rdy, 0);
      tick();
      wb_valid = 1; wb_rd = 9;
      @(negedge clk);
      chk1("fence_wait1", id_rdy, 0);
      tick();
      wb_rd = 10; fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd12};
      @(negedge clk);
      chk1("fence_wait2", id_rdy, 0);
      tick();
      wb_valid = 0;
      @(negedge clk);
      chk1("fence_wait_fwd", id_rdy, 0);
      chk1("fence_wait_hazard", hazard, 1);
      tick();
      fwd_valid = 0;
      @(negedge clk);
      chk1("fence_release", id_rdy, 1);
      tick();
      id_fence = 0;
      @(negedge clk);
      chk1("fence_after", id_rdy, 1);
      tick();

      // reset in the middle of a drain
      id_long = 1; rd = 11;
      tick();
      id_long = 0; rd = 0; id_fence = 1;
      tick();
      @(negedge clk);
      chk1("drain_hold", id_rdy, 0);
      tick();
      rst = 1;
      @(negedge clk);
      chk1("drain_rst_id_clear", id_clr, 1);
      tick();
      clr_in();
      id_valid = 1;
      @(negedge clk);
      chk1("drain_rst_sb_busy", sb_busy, 0);
      chk1("drain_rst_id_ready", id_rdy, 1);
      tick();

      // random traffic against the model
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         id_valid = ($urandom_range(0, 3) != 0);
         ua = $urandom_range(0, 1); ub = $urandom_range(0, 1);
         ra = AW'($urandom_range(0, 7)); rb = AW'($urandom_range(0, 7));
         rd = AW'($urandom_range(0, 7));
         id_long = ($urandom_range(0, 2) == 0);
         id_fence = ($urandom_range(0, 9) == 0);
         fwd_valid = NF'($urandom_range(0, 3));
         fwd_rdy = NF'($urandom_range(0, 3));
         fwd_rd = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         fwd_data = {$urandom, $urandom};
         wb_valid = ($urandom_range(0, 2) == 0);
         wb_rd = AW'($urandom_range(0, 7));
         branch = ($urandom_range(0, 9) == 0);
         stall = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         model_eval();
         chk1("rnd_if_ready", if_rdy, e_if);
         chk1("rnd_id_ready", id_rdy, e_id);
         chk1("rnd_ex_ready", ex_rdy, e_ex);
         chk1("rnd_id_clear", id_clr, e_idc);
         chk1("rnd_ex_clear", ex_clr, e_exc);
         chk1("rnd_hazard", hazard, !e_if);
         chk1("rnd_a_en", a_en, e_aen);
         chk1("rnd_b_en", b_en, e_ben);
         chkd("rnd_a_data", a_data, e_ad);
         chkd("rnd_b_data", b_data, e_bd);
         chk1("rnd_sb_busy", sb_busy, busy_r);
         model_step();
         tick();
      end
`ifdef IOT_RISCV_HAZARD_PERF_EN
      clr_in();
      stall = 1;
      @(negedge clk);
      chkd("perf_stall_cnt", p_stall, m_stall_n);
      chkd("perf_flush_cnt", p_flush, m_flush_n);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iot_riscv_hazard_ctrl.md
Name: iot_riscv_hazard_ctrl

Overview:
- Parametrised next-generation hazard controller for the iot_riscv in-order pipeline.
- Adds per-register scoreboard for long-latency ops (load, CSR, mul/div), N-stage priority forwarding with independent A/B data, WAW stall, multi-cycle branch flush and fence drain FSM.
- Sits beside decode; drives ready/clear of IF/ID/EX pipeline registers and operand forwarding muxes.

Parameters:
- DW, 32, datapath width.
- REG_AW, 5, register index width (4 = RV32E).
- NFWD, 2, number of forwarding sources; index 0 = nearest (youngest) stage.
- FLUSH_CYC, 1, cycles ID is cleared after a taken branch (1..4).

Ports:
- main_clk_i  in  1  clock.
- main_rst_i  in  1  synchronous active-high reset.
- id_valid_i  in  1  valid instruction in ID.
- id_ra_index_i, id_rb_index_i  in  REG_AW  source indices.
- id_uses_ra_i, id_uses_rb_i  in  1  operand actually read.
- id_rd_index_i  in  REG_AW  destination index.
- id_long_i  in  1  ID instr is long-latency (completes via wb port).
- id_fence_i  in  1  ID instr is fence.
- fwd_valid_i  in  NFWD  stage k holds register-writing instr.
- fwd_rdy_i  in  NFWD  stage k result available this cycle.
- fwd_rd_index_i  in  NFWD*REG_AW  stage k destination.
- fwd_data_i  in  NFWD*DW  stage k result.
- wb_valid_i  in  1  long-latency completion.
- wb_rd_index_i  in  REG_AW  completing destination.
- branch_taken_i  in  1  taken branch/jump resolved in EX.
- pipe_stall_i  in  1  backend (EX/MEM) busy.
- if_ready_o, id_ready_o, ex_ready_o  out  1  stage advance enables.
- id_clear_o, ex_clear_o  out  1  insert bubble.
- hazard_o  out  1  = !if_ready_o.
- fwd_a_en_o, fwd_b_en_o  out  1  forward select.
- fwd_a_data_o, fwd_b_data_o  out  DW  forwarded operand.
- sb_busy_o  out  1  any scoreboard bit set (registered).

Behaviour:
- Reset (main_rst_i=1): scoreboard cleared, FSM=RUN, flush counter 0; while asserted if/id/ex_ready_o=0, id_clear_o=ex_clear_o=1, fwd_*=0, sb_busy_o=0 next cycle. Reset mid-flush/drain aborts to RUN.
- Match(X,k): uses_X & idx!=0 & fwd_valid_i[k] & fwd_rd_index[k]==idx. Lowest matching k wins; forward iff fwd_rdy_i[k]=1, else data stall. Forward path combinational, 0 latency.
- Scoreboard: bit[rd] set on issue (id_valid_i & id_ready_o & id_long_i & rd!=0); cleared on wb_valid_i. Same-index set+clear same cycle: set wins. Register 0 never set.
- RAW stall: operand read whose scoreboard bit is set and not covered by a ready forwarding match. Clear visible next cycle only.
- WAW stall: id_long_i=0 instr with rd pending in scoreboard.
- Data stall action: if_ready_o=0, id_ready_o=0, ex_clear_o=1.
- Priority (highest first): reset, pipe_stall_i (all readies 0, no clears), FLUSH/branch, DRAIN, data stall, !id_valid_i (id_clear_o=1).
- FSM RUN: branch_taken_i -> id_clear_o=1 that cycle; if FLUSH_CYC>1 go FLUSH, cnt=FLUSH_CYC-1. Branch while pipe_stall_i=1 is latched and applied on first non-stall cycle.
- FSM FLUSH: id_clear_o=1, id_ready_o=0; cnt decrements each non-stalled cycle; exit to RUN at 0. New branch in FLUSH reloads cnt.
- FSM DRAIN: entered when id_valid_i & id_fence_i in RUN; id_ready_o=0, ex_clear_o=1 until scoreboard empty and fwd_valid_i==0, then RUN with fence released same cycle.

Optional Feature:
- IOT_RISCV_HAZARD_PERF_EN: adds outputs perf_stall_cnt_o[31:0] (data stall cycles) and perf_flush_cnt_o[31:0] (flush cycles), saturating at all-ones, cleared by reset. Without macro: ports and counters absent; no other behavioural difference.

Decomposition:
- Package iot_riscv_hazard_pkg: FSM enum (RUN, FLUSH, DRAIN), flush counter width constant, helper function for index compare with x0 suppression.
- Sub-module iot_riscv_hazard_fwd_sel: priority match/mux for one operand over NFWD sources (outputs en, data, hit_not_ready); instantiated twice.

Test Plan:
- fwd_valid=2'b11, both rd=5, rdy=2'b01, id_ra=5 -> fwd_a_en_o=1, fwd_a_data_o=fwd_data[0], no stall.
- Long load rd=7 issued, next instr reads x7, fwd_valid=0 -> hazard_o=1 until cycle after wb_valid_i with rd=7, then id_ready_o=1.
- Same cycle issue long rd=3 and wb_valid rd=3 -> bit[3] remains set, sb_busy_o=1.
- FLUSH_CYC=3, branch_taken_i pulse -> id_clear_o high exactly 3 cycles; branch under pipe_stall_i -> flush starts first non-stall cycle.
- Fence with two pending loads -> id_ready_o=0 until both wb done and fwd_valid=0, then released; reset asserted mid-DRAIN -> RUN, sb_busy_o=0.
- id_ra=0 with fwd_rd=0 valid -> fwd_a_en_o=0, no stall.
